// File: rtl/dlx_pipe_if.sv
// DLX instruction-fetch stage: drives the instruction-memory handshake and the IF/ID
// register, handling stalls, cache freezes, taken branches and trap/illegal halts.
module dlx_pipe_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        dc_wait,
    input  logic        id_cond,
    input  logic [31:0] id_npc,
    input  logic        id_halt,
    input  logic        id_illegal_instr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_npc,
    output logic        if_halted,
    output logic        if_illegal
);

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALT
    } state_e;

    state_e      state;
    logic [31:0] pc;
    logic [31:0] hold_ir;
    logic        hold_valid;
    logic [31:0] redir_pc;
    logic        redir_pend;

    logic        adv;
    logic        req_ack;
    logic        avail;
    logic [31:0] word;
    logic [31:0] pc_inc;

    // A word accepted while the pipe cannot advance is parked in hold_ir, and the
    // request is withdrawn so the same address is never fetched twice.
    assign adv       = !stall && !dc_wait;
    assign req_ack   = imem_req && imem_ack;
    assign avail     = hold_valid || req_ack;
    assign word      = hold_valid ? hold_ir : imem_rdata;
    assign pc_inc    = pc + 32'd4;
    assign imem_addr = pc;
    assign imem_req  = ((state == FETCH) && !hold_valid) || (state == DRAIN);

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would let later branches see updated pc/state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            if_id_ir   <= NOP_WORD;
            if_id_npc  <= RESET_PC;
            // NOTE: the parked word and redirect target are reset too; they are only
            // two registers, and a known value keeps simulation free of X propagation.
            hold_ir    <= NOP_WORD;
            hold_valid <= 1'b0;
            redir_pc   <= RESET_PC;
            redir_pend <= 1'b0;
            if_halted  <= 1'b0;
            if_illegal <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!adv) begin
                        if (req_ack) begin
                            hold_ir    <= imem_rdata;
                            hold_valid <= 1'b1;
                        end
                    end else if (id_halt || id_illegal_instr) begin
                        if_id_ir   <= NOP_WORD;
                        hold_valid <= 1'b0;
                        redir_pend <= 1'b0;
                        if (id_illegal_instr) begin
                            if_illegal <= 1'b1;
                        end
                        // An in-flight request must complete before the bus goes idle.
                        if (imem_req && !imem_ack) begin
                            state <= DRAIN;
                        end else begin
                            state     <= HALT;
                            if_halted <= 1'b1;
                        end
                    end else if (id_cond) begin
                        if_id_ir <= NOP_WORD;
                        if (avail) begin
                            pc         <= id_npc;
                            hold_valid <= 1'b0;
                            redir_pend <= 1'b0;
                        end else begin
                            redir_pend <= 1'b1;
                            redir_pc   <= id_npc;
                        end
                    end else if (redir_pend) begin
                        if_id_ir <= NOP_WORD;
                        if (avail) begin
                            pc         <= redir_pc;
                            redir_pend <= 1'b0;
                            hold_valid <= 1'b0;
                        end
                    end else if (avail) begin
                        if_id_ir   <= word;
                        if_id_npc  <= pc_inc;
                        pc         <= pc_inc;
                        hold_valid <= 1'b0;
                    end else begin
                        if_id_ir <= NOP_WORD;
                    end
                end
                DRAIN: begin
                    if_id_ir <= NOP_WORD;
                    if (imem_ack) begin
                        state     <= HALT;
                        if_halted <= 1'b1;
                    end
                end
                HALT: begin
                    if_id_ir  <= NOP_WORD;
                    if_halted <= 1'b1;
                end
                // NOTE: the unused fourth encoding recovers to FETCH instead of locking up.
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlx_pipe_if.sv
// Self-checking bench for dlx_pipe_if: per-cycle expectations are queued with the
// stimulus and compared against the outputs one time unit after the clock edge.
module tb_dlx_pipe_if;

    localparam logic [31:0] NOP = 32'h5400_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        dc_wait;
    logic        id_cond;
    logic [31:0] id_npc;
    logic        id_halt;
    logic        id_illegal_instr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_npc;
    logic        if_halted;
    logic        if_illegal;

    always #5 clk = ~clk;

    dlx_pipe_if #(
        .RESET_PC(32'h0000_0000),
        .NOP_WORD(NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .dc_wait         (dc_wait),
        .id_cond         (id_cond),
        .id_npc          (id_npc),
        .id_halt         (id_halt),
        .id_illegal_instr(id_illegal_instr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_ack        (imem_ack),
        .if_id_ir        (if_id_ir),
        .if_id_npc       (if_id_npc),
        .if_halted       (if_halted),
        .if_illegal      (if_illegal)
    );

    typedef enum {F_IR, F_NPC, F_ADDR, F_REQ, F_HALTED, F_ILLEGAL} field_e;
    typedef struct {
        string       tag;
        field_e      field;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   passed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] observe(input field_e f);
        case (f)
            F_IR:      return if_id_ir;
            F_NPC:     return if_id_npc;
            F_ADDR:    return imem_addr;
            F_REQ:     return {31'b0, imem_req};
            F_HALTED:  return {31'b0, if_halted};
            default:   return {31'b0, if_illegal};
        endcase
    endfunction

    // Instruction word stored at an address in the fake memory.
    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic push(input string tag, input field_e f, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.field = f;
        e.val   = v;
        sb.push_back(e);
    endtask

    task automatic exp_pipe(input string tag, input logic [31:0] ir, input logic [31:0] npc,
                            input logic [31:0] addr, input logic req);
        push({tag, ".ir"}, F_IR, ir);
        push({tag, ".npc"}, F_NPC, npc);
        push({tag, ".addr"}, F_ADDR, addr);
        push({tag, ".req"}, F_REQ, {31'b0, req});
    endtask

    task automatic exp_flags(input string tag, input logic halted, input logic illegal);
        push({tag, ".halted"}, F_HALTED, {31'b0, halted});
        push({tag, ".illegal"}, F_ILLEGAL, {31'b0, illegal});
    endtask

    task automatic drive(input logic s, input logic dw, input logic c, input logic [31:0] np,
                         input logic h, input logic il, input logic ak, input logic [31:0] rd);
        stall            = s;
        dc_wait          = dw;
        id_cond          = c;
        id_npc           = np;
        id_halt          = h;
        id_illegal_instr = il;
        imem_ack         = ak;
        imem_rdata       = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, observe(e.field), e.val);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        passed = 0;

        // Reset state
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        exp_pipe("rst", NOP, 32'h0, 32'h0, 1'b1);
        exp_flags("rst", 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Zero-wait stream A, B, C
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h0));
        exp_pipe("seq_a", w(32'h0), 32'h4, 32'h4, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h4));
        exp_pipe("seq_b", w(32'h4), 32'h8, 32'h8, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h8));
        exp_pipe("seq_c", w(32'h8), 32'hC, 32'hC, 1'b1);
        tick();

        // Taken jump with the ack present
        drive(0, 0, 1, 32'h100, 0, 0, 1, w(32'hC));
        exp_pipe("jmp_ack", NOP, 32'hC, 32'h100, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h100));
        exp_pipe("jmp_tgt", w(32'h100), 32'h104, 32'h104, 1'b1);
        tick();

        // Taken branch at pc=8 while the ack is late (reset mid-request first)
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h0));
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h4));
        exp_pipe("re_b", w(32'h4), 32'h8, 32'h8, 1'b1);
        tick();
        drive(0, 0, 1, 32'h100, 0, 0, 0, 0);
        exp_pipe("br_wait0", NOP, 32'h8, 32'h8, 1'b1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            exp_pipe($sformatf("br_wait%0d", i), NOP, 32'h8, 32'h8, 1'b1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h8));
        exp_pipe("br_late", NOP, 32'h8, 32'h100, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h100));
        exp_pipe("br_tgt", w(32'h100), 32'h104, 32'h104, 1'b1);
        tick();

        // A newer branch overrides a pending redirect
        drive(0, 0, 1, 32'h300, 0, 0, 0, 0);
        exp_pipe("rr_a", NOP, 32'h104, 32'h104, 1'b1);
        tick();
        drive(0, 0, 1, 32'h400, 0, 0, 0, 0);
        exp_pipe("rr_b", NOP, 32'h104, 32'h104, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h104));
        exp_pipe("rr_c", NOP, 32'h104, 32'h400, 1'b1);
        tick();

        // Stall while a word is acked: parked, no re-fetch, ack with req=0 ignored
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h400));
        exp_pipe("st_pre", w(32'h400), 32'h404, 32'h404, 1'b1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, w(32'h404));
        exp_pipe("st_cap", w(32'h400), 32'h404, 32'h404, 1'b0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
        exp_pipe("st_hold", w(32'h400), 32'h404, 32'h404, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 32'hBAD0_BAD0);
        exp_pipe("st_rel", w(32'h404), 32'h408, 32'h408, 1'b1);
        tick();

        // pc+4 wraps at the top of the address space
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, w(32'h408));
        exp_pipe("wr_jmp", NOP, 32'h408, 32'hFFFF_FFFC, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, w(32'hFFFF_FFFC));
        exp_pipe("wr_wrap", w(32'hFFFF_FFFC), 32'h0, 32'h0, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h0));
        exp_pipe("wr_next", w(32'h0), 32'h4, 32'h4, 1'b1);
        tick();

        // Trap with an outstanding request: DRAIN, then HALT, then reset restart
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        exp_pipe("hl_drain", NOP, 32'h4, 32'h4, 1'b1);
        exp_flags("hl_drain", 1'b0, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        exp_pipe("hl_drain2", NOP, 32'h4, 32'h4, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h4));
        exp_pipe("hl_halt", NOP, 32'h4, 32'h4, 1'b0);
        exp_flags("hl_halt", 1'b1, 1'b0);
        tick();
        drive(0, 0, 1, 32'h500, 0, 0, 1, 32'hBAD0_BAD0);
        exp_pipe("hl_stay", NOP, 32'h4, 32'h4, 1'b0);
        exp_flags("hl_stay", 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        exp_pipe("hl_rst", NOP, 32'h0, 32'h0, 1'b1);
        exp_flags("hl_rst", 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, w(32'h0));
        exp_pipe("hl_restart", w(32'h0), 32'h4, 32'h4, 1'b1);
        tick();

        // Illegal opcode is ignored under dc_wait, acted on once it falls
        drive(0, 1, 0, 0, 0, 1, 0, 0);
        exp_pipe("il_frz", w(32'h0), 32'h4, 32'h4, 1'b1);
        exp_flags("il_frz", 1'b0, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1, w(32'h4));
        exp_pipe("il_halt", NOP, 32'h4, 32'h4, 1'b0);
        exp_flags("il_halt", 1'b1, 1'b1);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
